seg_scan: RTL and testbench



---
 rtl/seg_scan.sv | 125 ++++++++++++
 tb/tb_seg_scan.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// 4-digit common-anode 7-segment scanner showing the last four distinct core results.
// Build option: define SEG_HEX_EN for hex glyphs on 10..15; otherwise those values show a dash.
module seg_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] val_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] r_pre;
  logic [1:0]  r_idx;
  logic        r_primed;
  logic [3:0]  r_last;
  logic [3:0]  r_hist [4];
  logic [3:0]  r_v;
  logic        r_fresh;
  logic [6:0]  r_seg;
  logic [3:0]  r_an;
  logic        r_dp;

  logic        w_push;
  logic        w_tc;
  logic        w_wrap;
  logic [3:0]  w_sel;
  logic [6:0]  w_seg_next;
  logic [3:0]  w_an_next;
  logic        w_dp_next;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
`ifdef SEG_HEX_EN
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
`else
      default: g = 7'b0111111;
`endif
    endcase
    return g;
  endfunction

  // The first sample after reset always pushes, even if it equals the cleared last value.
  assign w_push = !r_primed || (val_in != r_last);
  assign w_tc   = (r_pre == PRE_LAST);
  assign w_wrap = w_tc && (r_idx == 2'd3);

  always_comb begin
    w_sel      = r_hist[r_idx];
    w_seg_next = r_v[r_idx] ? glyph(w_sel) : 7'b1111111;
    w_an_next  = ~(4'b0001 << r_idx);
    w_dp_next  = !((r_idx == 2'd0) && r_fresh);
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let hist[k] see hist[k-1]'s new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_primed <= 1'b0;
      r_last   <= '0;
      r_v      <= '0;
      r_fresh  <= 1'b0;
      // NOTE: the history is only four small registers, so it is reset like any
      // other state; a larger RAM-style history would rely on the valid bits instead.
      for (int k = 0; k < 4; k++) r_hist[k] <= '0;
    end else begin
      if (w_tc) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + 16'd1;
      end

      if (w_push) begin
        r_hist[0] <= val_in;
        for (int k = 1; k < 4; k++) r_hist[k] <= r_hist[k-1];
        r_v      <= {r_v[2:0], 1'b1};
        r_last   <= val_in;
        r_primed <= 1'b1;
      end

      // A push on the wrap cycle keeps the flag set for the coming digit-0 slot.
      if (w_push)      r_fresh <= 1'b1;
      else if (w_wrap) r_fresh <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= 7'b1111111;
      r_an  <= 4'b1110;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
      r_dp  <= w_dp_next;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4; cycle k means the negedge after the k-th
// rising edge since reset release, where the displayed digit is ((k-1)/4) mod 4.
module tb_seg_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] val_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [6:0] BL = 7'b1111111;

  always #5 clk = ~clk;

  seg_scan #(.SCAN_DIV(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .val_in (val_in),
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  function automatic logic [6:0] exp_glyph(input logic [3:0] nib);
    case (nib)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
`ifdef SEG_HEX_EN
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
`else
      default: return 7'b0111111;
`endif
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  // Expected display at cycle cyc given the glyphs of digits 0..3 and the dp level.
  task automatic check_display(input string tag, input logic [6:0] g0, input logic [6:0] g1,
                               input logic [6:0] g2, input logic [6:0] g3, input logic exp_dp);
    int d;
    logic [6:0] es;
    d = ((cyc - 1) / 4) % 4;
    case (d)
      0:       es = g0;
      1:       es = g1;
      2:       es = g2;
      default: es = g3;
    endcase
    check({tag, " seg"}, seg, es);
    check({tag, " an"}, {3'b0, an}, {3'b0, ~(4'b0001 << d)});
    check({tag, " dp"}, {6'b0, dp}, {6'b0, exp_dp});
  endtask

  initial begin
    reset  = 1'b1;
    val_in = 4'd0;
    tick(3);
    check("reset seg", seg, BL);
    check("reset an", {3'b0, an}, 7'b0001110);
    check("reset dp", {6'b0, dp}, 7'd1);

    // First push: release with val_in=0 held.
    reset = 1'b0;
    cyc   = 0;
    tick(1);
    check("push1 seg", seg, BL);
    check("push1 an", {3'b0, an}, 7'b0001110);
    check("push1 v", {3'b0, dut.r_v}, 7'b0000001);
    tick(1);
    check("push2 seg", seg, 7'b1000000);
    check("push2 an", {3'b0, an}, 7'b0001110);
    check("push2 dp", {6'b0, dp}, 7'd0);
    while (cyc < 49) begin
      tick(1);
      check_display("blank", exp_glyph(4'd0), BL, BL, BL, (cyc <= 4) ? 1'b0 : 1'b1);
    end

    // History shift: 3,7,9,5 each for 10 cycles; the push of 5 lands on the frame wrap (edge 80).
    val_in = 4'd3; tick(10);
    val_in = 4'd7; tick(10);
    val_in = 4'd9; tick(10);
    val_in = 4'd5; tick(1);
    tick(1);
    check("wrap-push dp", {6'b0, dp}, 7'd0);
    check("wrap-push seg", seg, exp_glyph(4'd5));
    tick(8);
    while (cyc < 189) begin
      tick(1);
      check_display("hist", exp_glyph(4'd5), exp_glyph(4'd9), exp_glyph(4'd7),
                    exp_glyph(4'd3), 1'b1);
    end

    // Push 2 during the idx==2 slot (edge 201); the wrap at edge 208 clears fresh.
    tick(11);
    val_in = 4'd2;
    tick(1);
    check("pre-shift d2", seg, exp_glyph(4'd7));
    tick(1);
    check("post-shift d2", seg, exp_glyph(4'd9));
    tick(6);
    while (cyc < 212) begin
      tick(1);
      check_display("fresh", exp_glyph(4'd2), exp_glyph(4'd5), exp_glyph(4'd9),
                    exp_glyph(4'd7), 1'b1);
    end

    // Values above 9: push A then F.
    val_in = 4'hA; tick(1);
    val_in = 4'hF; tick(1);
    while (cyc < 230) begin
      tick(1);
      check_display("hex", exp_glyph(4'hF), exp_glyph(4'hA), exp_glyph(4'd2),
                    exp_glyph(4'd5), 1'b1);
    end

    // Asynchronous reset mid-frame (digit 1 currently shown), checked before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("async seg", seg, BL);
    check("async an", {3'b0, an}, 7'b0001110);
    check("async dp", {6'b0, dp}, 7'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
